// File: rtl/key_state_tracker.sv
// PS/2 set-2 scan-code decoder that keeps a held/pressed/released map of seven game controls.
// Define KEYSTATE_PREFIX_TIMEOUT_EN to compile in the abandon-stale-prefix timeout.
module key_state_tracker #(
   parameter int unsigned PREFIX_TIMEOUT = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       code_valid,
   input  logic [7:0] code,
   input  logic       frame_tick,
   output logic [6:0] held,
   output logic [6:0] press_pulse,
   output logic [6:0] release_pulse,
   output logic [6:0] pressed,
   output logic [6:0] released
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   state_e     state_q, state_d;
   logic [6:0] held_q, held_d;
   logic [6:0] press_q, press_d;
   logic [6:0] release_q, release_d;
   logic [6:0] pressed_q, pressed_d;
   logic [6:0] released_q, released_d;
   logic       make, brk, ext;
   logic [6:0] key_hit;

   // Exact (ext, byte) match; anything unmapped yields an empty mask.
   function automatic logic [6:0] key_mask(input logic ext_i, input logic [7:0] byte_i);
      logic [6:0] m;
      m = '0;
      case ({ext_i, byte_i})
         9'h16B:  m = 7'b000_0001;
         9'h174:  m = 7'b000_0010;
         9'h175:  m = 7'b000_0100;
         9'h172:  m = 7'b000_1000;
         9'h012:  m = 7'b001_0000;
         9'h01A:  m = 7'b010_0000;
         9'h02D:  m = 7'b100_0000;
         default: m = '0;
      endcase
      return m;
   endfunction

`ifdef KEYSTATE_PREFIX_TIMEOUT_EN
   localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_expired;

   assign tmo_cnt_d   = (code_valid || state_q == IDLE) ? '0 : tmo_cnt_q + 1'b1;
   assign tmo_expired = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(PREFIX_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (code_valid) begin
         case (state_q)
            IDLE:    state_d = (code == CODE_EXT) ? EXT : (code == CODE_BRK) ? BRK : IDLE;
            EXT:     state_d = (code == CODE_EXT) ? EXT : (code == CODE_BRK) ? EXT_BRK : IDLE;
            BRK:     state_d = (code == CODE_EXT) ? EXT : (code == CODE_BRK) ? BRK : IDLE;
            EXT_BRK: state_d = (code == CODE_EXT) ? EXT : (code == CODE_BRK) ? EXT_BRK : IDLE;
            default: state_d = IDLE;
         endcase
      end
`ifdef KEYSTATE_PREFIX_TIMEOUT_EN
      else if (tmo_expired) begin
         state_d = IDLE;
      end
`endif
   end

   // A non-prefix byte completes a make or break in the current state.
   always_comb begin
      make    = 1'b0;
      brk     = 1'b0;
      ext     = (state_q == EXT) || (state_q == EXT_BRK);
      key_hit = '0;
      if (code_valid && code != CODE_EXT && code != CODE_BRK) begin
         make    = (state_q == IDLE) || (state_q == EXT);
         brk     = (state_q == BRK)  || (state_q == EXT_BRK);
         key_hit = key_mask(ext, code);
      end
   end

   always_comb begin
      held_d = held_q;
      if (make)     held_d = held_q | key_hit;
      else if (brk) held_d = held_q & ~key_hit;
      press_d    = held_d & ~held_q;
      release_d  = held_q & ~held_d;
      // A new edge in the same cycle as frame_tick keeps its sticky flag.
      pressed_d  = (frame_tick ? 7'h00 : pressed_q)  | press_d;
      released_d = (frame_tick ? 7'h00 : released_q) | release_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_q     <= '0;
         press_q    <= '0;
         release_q  <= '0;
         pressed_q  <= '0;
         released_q <= '0;
      end else begin
         held_q     <= held_d;
         press_q    <= press_d;
         release_q  <= release_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   assign held          = held_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign pressed       = pressed_q;
   assign released      = released_q;

endmodule

// File: tb/tb_key_state_tracker.sv
// Directed bench for key_state_tracker; expectation for the prefix-timeout case
// follows KEYSTATE_PREFIX_TIMEOUT_EN.
module tb_key_state_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       code_valid = 1'b0;
   logic [7:0] code = 8'h00;
   logic       frame_tick = 1'b0;
   logic [6:0] held, press_pulse, release_pulse, pressed, released;

   int checks   = 0;
   int failures = 0;

   key_state_tracker #(.PREFIX_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code(code), .frame_tick(frame_tick),
      .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .pressed(pressed), .released(released)
   );

   always #5 clk = ~clk;

   // Entered and left at a falling edge; outputs are then those after the consuming edge.
   task automatic send(input logic [7:0] b, input logic tick = 1'b0);
      code_valid = 1'b1;
      code       = b;
      frame_tick = tick;
      @(negedge clk);
      code_valid = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      checks++;
      if ({held, press_pulse, release_pulse, pressed, released} !== 35'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {held, press_pulse, release_pulse, pressed, released});
      end
   endtask

   task automatic test_shoot();
      send(8'h1A);
      checks++; if (held !== 7'h20) begin failures++; $display("FAIL shoot_held got=%h exp=20", held); end
      checks++; if (press_pulse !== 7'h20) begin failures++; $display("FAIL shoot_press got=%h exp=20", press_pulse); end
      idle(1);
      checks++; if (press_pulse !== 7'h00) begin failures++; $display("FAIL shoot_press_1cyc got=%h exp=00", press_pulse); end
      send(8'hF0);
      checks++; if (held !== 7'h20) begin failures++; $display("FAIL shoot_held_after_f0 got=%h exp=20", held); end
      send(8'h1A);
      checks++; if (held !== 7'h00) begin failures++; $display("FAIL shoot_held_rel got=%h exp=00", held); end
      checks++; if (release_pulse !== 7'h20) begin failures++; $display("FAIL shoot_release got=%h exp=20", release_pulse); end
      idle(1);
      checks++; if (release_pulse !== 7'h00) begin failures++; $display("FAIL shoot_release_1cyc got=%h exp=00", release_pulse); end
      tick();
   endtask

   task automatic test_typematic();
      int presses = 0;
      send(8'hE0);
      send(8'h6B);
      checks++; if (held !== 7'h01) begin failures++; $display("FAIL typ_held got=%h exp=01", held); end
      presses += int'(press_pulse[0]);
      tick();
      for (int r = 0; r < 2; r++) begin
         send(8'hE0);
         send(8'h6B);
         presses += int'(press_pulse[0]);
      end
      checks++; if (presses !== 1) begin failures++; $display("FAIL typ_press_count got=%0d exp=1", presses); end
      checks++; if (pressed !== 7'h00) begin failures++; $display("FAIL typ_pressed_unchanged got=%h exp=00", pressed); end
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      checks++; if (held !== 7'h00) begin failures++; $display("FAIL typ_held_rel got=%h exp=00", held); end
      checks++; if (release_pulse !== 7'h01) begin failures++; $display("FAIL typ_release got=%h exp=01", release_pulse); end
      tick();
   endtask

   task automatic test_fake_shift();
      send(8'hE0);
      send(8'h12);
      checks++; if (held !== 7'h00) begin failures++; $display("FAIL fake_shift_held got=%h exp=00", held); end
      checks++; if (press_pulse !== 7'h00) begin failures++; $display("FAIL fake_shift_press got=%h exp=00", press_pulse); end
      send(8'h12);
      checks++; if (held !== 7'h10) begin failures++; $display("FAIL shift_held got=%h exp=10", held); end
      send(8'hF0);
      send(8'h12);
      checks++; if (held !== 7'h00) begin failures++; $display("FAIL shift_held_rel got=%h exp=00", held); end
      tick();
   endtask

   task automatic test_sticky();
      send(8'h2D);
      send(8'hF0);
      send(8'h2D);
      idle(3);
      checks++; if (pressed !== 7'h40) begin failures++; $display("FAIL sticky_pressed got=%h exp=40", pressed); end
      checks++; if (released !== 7'h40) begin failures++; $display("FAIL sticky_released got=%h exp=40", released); end
      tick();
      checks++; if ({pressed, released} !== 14'h0) begin failures++; $display("FAIL sticky_clear got=%h exp=0", {pressed, released}); end
      send(8'h2D, 1'b1);
      checks++; if (press_pulse !== 7'h40) begin failures++; $display("FAIL tick_press_pulse got=%h exp=40", press_pulse); end
      checks++; if (pressed !== 7'h40) begin failures++; $display("FAIL tick_set_wins got=%h exp=40", pressed); end
      // Break of a key that is not held.
      send(8'hF0);
      send(8'h1A);
      checks++; if (release_pulse !== 7'h00) begin failures++; $display("FAIL unheld_break_pulse got=%h exp=00", release_pulse); end
      checks++; if (held !== 7'h40) begin failures++; $display("FAIL unheld_break_held got=%h exp=40", held); end
      send(8'hF0);
      send(8'h2D);
      tick();
      checks++; if ({held, pressed, released} !== 21'h0) begin failures++; $display("FAIL sticky_final got=%h exp=0", {held, pressed, released}); end
   endtask

   task automatic test_back_to_back();
      send(8'h1A);
      send(8'h2D);
      checks++; if (held !== 7'h60) begin failures++; $display("FAIL b2b_held got=%h exp=60", held); end
      checks++; if (press_pulse !== 7'h40) begin failures++; $display("FAIL b2b_press got=%h exp=40", press_pulse); end
      checks++; if (pressed !== 7'h60) begin failures++; $display("FAIL b2b_pressed got=%h exp=60", pressed); end
      send(8'hF0);
      send(8'h1A);
      send(8'hF0);
      send(8'h2D);
      checks++; if (held !== 7'h00) begin failures++; $display("FAIL b2b_held_rel got=%h exp=00", held); end
      tick();
   endtask

   task automatic test_timeout();
      logic [6:0] exp_held;
`ifdef KEYSTATE_PREFIX_TIMEOUT_EN
      exp_held = 7'h00;
`else
      exp_held = 7'h01;
`endif
      send(8'hE0);
      idle(20);
      send(8'h6B);
      checks++; if (held !== exp_held) begin failures++; $display("FAIL timeout_abandon got=%h exp=%h", held, exp_held); end
      if (held[0]) begin
         send(8'hE0);
         send(8'hF0);
         send(8'h6B);
      end
      tick();
      // Byte arriving on the very cycle the counter reaches its limit is still decoded as extended.
      send(8'hE0);
      idle(15);
      send(8'h6B);
      checks++; if (held !== 7'h01) begin failures++; $display("FAIL timeout_byte_wins got=%h exp=01", held); end
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      tick();
   endtask

   task automatic test_reset_mid();
      send(8'h12);
      checks++; if (held !== 7'h10) begin failures++; $display("FAIL rstmid_held_pre got=%h exp=10", held); end
      send(8'hF0);
      rst        = 1'b1;
      code_valid = 1'b1;
      code       = 8'h1A;
      @(negedge clk);
      rst        = 1'b0;
      code_valid = 1'b0;
      checks++;
      if ({held, press_pulse, release_pulse, pressed, released} !== 35'h0) begin
         failures++;
         $display("FAIL rstmid_outputs got=%h exp=0", {held, press_pulse, release_pulse, pressed, released});
      end
      send(8'h12);
      checks++; if (held !== 7'h10) begin failures++; $display("FAIL rstmid_make_held got=%h exp=10", held); end
      checks++; if (press_pulse !== 7'h10) begin failures++; $display("FAIL rstmid_make_press got=%h exp=10", press_pulse); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_shoot();
      test_typematic();
      test_fake_shift();
      test_sticky();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
